// File: rtl/adc_cal_pkg.sv
// Shared widths, constants and state encoding for the phase-current calibration block.
package adc_cal_pkg;

  localparam int ADC_W = 12;
  localparam logic [ADC_W-1:0] OFFSET_MID = 12'd2048;
  localparam logic signed [ADC_W-1:0] SAT_MAX = 12'sh7FF;
  localparam logic signed [ADC_W-1:0] SAT_MIN = 12'sh800;

  typedef enum logic [1:0] {
    ST_CAL    = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RUN    = 2'd2
  } cal_state_e;

  // A 13-bit difference fits 12 bits only while its top two bits agree.
  function automatic logic signed [ADC_W-1:0] sat_to_adc(input logic signed [ADC_W:0] d);
    if (d[ADC_W] != d[ADC_W-1]) begin
      return d[ADC_W] ? SAT_MIN : SAT_MAX;
    end
    return d[ADC_W-1:0];
  endfunction

endpackage

// File: rtl/adc_sub_sat.sv
// Unsigned ADC word minus unsigned offset, saturated to a signed ADC-width current.
module adc_sub_sat
  import adc_cal_pkg::*;
(
  input  logic        [ADC_W-1:0] adc_i,
  input  logic        [ADC_W-1:0] off_i,
  output logic signed [ADC_W-1:0] diff_o
);

  logic signed [ADC_W:0] diff_full;

  assign diff_full = $signed({1'b0, adc_i}) - $signed({1'b0, off_i});
  assign diff_o    = sat_to_adc(diff_full);

endmodule

// File: rtl/adc_current_cal.sv
// Learns per-phase zero-current ADC offsets, then emits offset-corrected saturated currents.
module adc_current_cal
  import adc_cal_pkg::*;
#(
  parameter int               AVG_LOG2   = 6,
  parameter logic [ADC_W-1:0] OFFSET_TOL = 12'd256
) (
  input  logic                    rstn,
  input  logic                    clk,
  input  logic                    i_cal_start,
  input  logic                    i_en_adc,
  input  logic        [ADC_W-1:0] i_adc_a,
  input  logic        [ADC_W-1:0] i_adc_b,
  input  logic        [ADC_W-1:0] i_adc_c,
  output logic                    o_cal_busy,
  output logic                    o_cal_done,
  output logic                    o_cal_err,
  output logic                    o_en_i,
  output logic signed [ADC_W-1:0] o_ia,
  output logic signed [ADC_W-1:0] o_ib,
  output logic signed [ADC_W-1:0] o_ic,
  output cal_state_e              o_dbg_state
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [ACC_W:0]   RND      = (ACC_W+1)'((1 << AVG_LOG2) >> 1);

  // i_en_adc is a one-cycle valid with no ready: every strobe is consumed the
  // cycle it arrives (accumulated in CAL, corrected in RUN, dropped in COMMIT),
  // and i_cal_start in the same cycle takes priority so that sample is discarded.

  cal_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic en_q, en_d;

  logic        [ACC_W-1:0] acc_q   [3];
  logic        [ACC_W-1:0] acc_d   [3];
  logic        [ADC_W-1:0] off_q   [3];
  logic        [ADC_W-1:0] off_d   [3];
  logic signed [ADC_W-1:0] i_q     [3];
  logic signed [ADC_W-1:0] i_d     [3];

  logic        [ADC_W-1:0] adc_in  [3];
  logic signed [ADC_W-1:0] sub_out [3];
  logic        [ACC_W:0]   rnd_sum [3];
  logic        [ADC_W-1:0] off_new [3];
  logic signed [ADC_W:0]   dev     [3];
  logic        [ADC_W:0]   mag     [3];
  logic        [2:0]       fail;

  assign adc_in[0] = i_adc_a;
  assign adc_in[1] = i_adc_b;
  assign adc_in[2] = i_adc_c;

  for (genvar g = 0; g < 3; g++) begin : g_sub
    adc_sub_sat u_sub (
      .adc_i  (adc_in[g]),
      .off_i  (off_q[g]),
      .diff_o (sub_out[g])
    );
  end

  // Rounded mean and its deviation from mid-scale, evaluated every cycle but
  // only committed in COMMIT.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      rnd_sum[ch] = {1'b0, acc_q[ch]} + RND;
      off_new[ch] = ADC_W'(rnd_sum[ch] >> AVG_LOG2);
      dev[ch]     = $signed({1'b0, off_new[ch]}) - $signed({1'b0, OFFSET_MID});
      mag[ch]     = dev[ch][ADC_W] ? (ADC_W+1)'(-dev[ch]) : (ADC_W+1)'(dev[ch]);
      fail[ch]    = (mag[ch] > {1'b0, OFFSET_TOL});
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    off_d   = off_q;
    i_d     = i_q;
    err_d   = err_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    if (i_cal_start) begin
      state_d = ST_CAL;
      cnt_d   = '0;
      err_d   = 1'b0;
      for (int ch = 0; ch < 3; ch++) acc_d[ch] = '0;
    end else begin
      case (state_q)
        ST_CAL: begin
          if (i_en_adc) begin
            for (int ch = 0; ch < 3; ch++) acc_d[ch] = acc_q[ch] + ACC_W'(adc_in[ch]);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          for (int ch = 0; ch < 3; ch++) off_d[ch] = fail[ch] ? OFFSET_MID : off_new[ch];
          err_d   = err_q | (|fail);
          done_d  = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (i_en_adc) begin
            i_d  = sub_out;
            en_d = 1'b1;
          end
        end
        default: state_d = ST_CAL;
      endcase
    end
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_CAL;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        acc_q[ch] <= '0;
        off_q[ch] <= OFFSET_MID;
        i_q[ch]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      off_q   <= off_d;
      i_q     <= i_d;
    end
  end

  assign o_cal_busy  = busy_q;
  assign o_cal_done  = done_q;
  assign o_cal_err   = err_q;
  assign o_en_i      = en_q;
  assign o_ia        = i_q[0];
  assign o_ib        = i_q[1];
  assign o_ic        = i_q[2];
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_adc_current_cal.sv
// Directed and randomized bench for adc_current_cal against an arithmetic reference model.
module tb_adc_current_cal;
  import adc_cal_pkg::*;

  localparam int L   = 2;
  localparam int N   = 1 << L;
  localparam int TOL = 256;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cal_start = 1'b0;
  logic en_adc = 1'b0;
  logic [11:0] adc_a = '0, adc_b = '0, adc_c = '0;
  logic cal_busy, cal_done, cal_err, en_i;
  logic signed [11:0] ia, ib, ic;
  cal_state_e dbg_state;

  int n_pass = 0;
  int n_total = 0;

  adc_current_cal #(.AVG_LOG2(L), .OFFSET_TOL(12'(TOL))) dut (
    .rstn        (rstn),
    .clk         (clk),
    .i_cal_start (cal_start),
    .i_en_adc    (en_adc),
    .i_adc_a     (adc_a),
    .i_adc_b     (adc_b),
    .i_adc_c     (adc_c),
    .o_cal_busy  (cal_busy),
    .o_cal_done  (cal_done),
    .o_cal_err   (cal_err),
    .o_en_i      (en_i),
    .o_ia        (ia),
    .o_ib        (ib),
    .o_ic        (ic),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 collecting samples, 1 committing, 2 correcting.
  int m_phase = 0;
  int m_cnt = 0;
  int m_sum[3] = '{0, 0, 0};
  int m_off[3] = '{2048, 2048, 2048};
  int e_i[3] = '{0, 0, 0};
  bit e_busy = 1'b1, e_done = 1'b0, e_err = 1'b0, e_en = 1'b0;

  always @(posedge clk or negedge rstn) begin
    int v[3];
    int d;
    if (!rstn) begin
      m_phase = 0; m_cnt = 0;
      for (int ch = 0; ch < 3; ch++) begin m_sum[ch] = 0; m_off[ch] = 2048; e_i[ch] = 0; end
      e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0; e_en = 1'b0;
    end else begin
      v[0] = int'(adc_a); v[1] = int'(adc_b); v[2] = int'(adc_c);
      e_done = 1'b0;
      e_en = 1'b0;
      if (cal_start) begin
        m_phase = 0; m_cnt = 0; e_err = 1'b0;
        for (int ch = 0; ch < 3; ch++) m_sum[ch] = 0;
      end else if (m_phase == 0) begin
        if (en_adc) begin
          for (int ch = 0; ch < 3; ch++) m_sum[ch] += v[ch];
          m_cnt++;
          if (m_cnt == N) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          d = (m_sum[ch] + N / 2) / N;
          if (d - 2048 > TOL || 2048 - d > TOL) begin d = 2048; e_err = 1'b1; end
          m_off[ch] = d;
        end
        e_done = 1'b1;
        m_phase = 2;
      end else if (en_adc) begin
        for (int ch = 0; ch < 3; ch++) begin
          d = v[ch] - m_off[ch];
          if (d > 2047) d = 2047;
          if (d < -2048) d = -2048;
          e_i[ch] = d;
        end
        e_en = 1'b1;
      end
      e_busy = (m_phase != 2);
    end
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(negedge clk) begin
    chk("busy", int'(cal_busy), int'(e_busy));
    chk("done", int'(cal_done), int'(e_done));
    chk("err", int'(cal_err), int'(e_err));
    chk("en_i", int'(en_i), int'(e_en));
    chk("ia", int'(ia), e_i[0]);
    chk("ib", int'(ib), e_i[1]);
    chk("ic", int'(ic), e_i[2]);
  end

  // driver: one call = one clock cycle of inputs
  task automatic cyc(input bit st, input bit en, input int a, input int b, input int c);
    cal_start = st;
    en_adc = en;
    adc_a = 12'(a); adc_b = 12'(b); adc_c = 12'(c);
    @(negedge clk);
    cal_start = 1'b0;
    en_adc = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic calibrate(input int a, input int b, input int c);
    for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, a, b, c);
    chk("done_early", int'(cal_done), 0);
    idle(1);
    chk("done_pulse", int'(cal_done), 1);
    chk("busy_fall", int'(cal_busy), 0);
    idle(1);
  endtask

  initial begin
    int ra, rb, rc;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(cal_busy), 1);
    chk("rst_en", int'(en_i), 0);
    chk("rst_ia", int'(ia), 0);
    chk("rst_state", int'(dbg_state), int'(ST_CAL));
    rstn = 1'b1;
    idle(1);

    // basic calibration and correction
    for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, 2040 + k, 2048, 2048);
    chk("done_2cyc_not_yet", int'(cal_done), 0);
    idle(1);
    chk("done_2cyc", int'(cal_done), 1);
    chk("busy_after_done", int'(cal_busy), 0);
    chk("model_off_a", m_off[0], 2042);
    idle(1);
    cyc(1'b0, 1'b1, 2100, 2048, 2000);
    chk("basic_en", int'(en_i), 1);
    chk("basic_ia", int'(ia), 58);
    chk("basic_ib", int'(ib), 0);
    chk("basic_ic", int'(ic), -48);
    idle(1);
    chk("hold_ia", int'(ia), 58);

    // saturation both ways
    cyc(1'b1, 1'b0, 0, 0, 0);
    calibrate(1800, 2048, 2048);
    chk("sat_noerr", int'(cal_err), 0);
    cyc(1'b0, 1'b1, 4095, 2048, 2048);
    chk("sat_pos", int'(ia), 2047);
    cyc(1'b1, 1'b0, 0, 0, 0);
    calibrate(2300, 2048, 2048);
    cyc(1'b0, 1'b1, 0, 2048, 2048);
    chk("sat_neg", int'(ia), -2048);

    // tolerance failure forces mid-scale and sets sticky error
    cyc(1'b1, 1'b0, 0, 0, 0);
    calibrate(2048, 2048, 1700);
    chk("tol_err", int'(cal_err), 1);
    cyc(1'b0, 1'b1, 2048, 2048, 1700);
    chk("tol_ic", int'(ic), -348);
    cyc(1'b1, 1'b0, 0, 0, 0);
    chk("tol_err_clr", int'(cal_err), 0);

    // start coincident with a strobe: sample discarded
    cyc(1'b1, 1'b1, 4000, 2048, 2048);
    chk("coll_busy", int'(cal_busy), 1);
    calibrate(2048, 2048, 2048);
    chk("coll_noerr", int'(cal_err), 0);
    cyc(1'b0, 1'b1, 2100, 2048, 2048);
    chk("coll_ia", int'(ia), 52);

    // restart mid-calibration needs a full fresh set
    cyc(1'b1, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 2200, 2048, 2048);
    cyc(1'b0, 1'b1, 2200, 2048, 2048);
    cyc(1'b1, 1'b0, 0, 0, 0);
    calibrate(2000, 2048, 2048);
    cyc(1'b0, 1'b1, 2100, 2048, 2048);
    chk("restart_ia", int'(ia), 100);

    // reset mid-calibration
    cyc(1'b1, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 2100, 2100, 2100);
    cyc(1'b0, 1'b1, 2100, 2100, 2100);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", int'(cal_busy), 1);
    chk("mid_rst_ia", int'(ia), 0);
    chk("mid_rst_en", int'(en_i), 0);
    rstn = 1'b1;
    idle(1);
    calibrate(2010, 2060, 2048);

    // back-to-back strobes in RUN
    cyc(1'b0, 1'b1, 2100, 2100, 2100);
    chk("b2b_ia", int'(ia), 90);
    chk("b2b_ib", int'(ib), 40);
    chk("b2b_ic", int'(ic), 52);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
      chk("b2b_en", int'(en_i), 1);
    end

    // randomized traffic including restarts and out-of-tolerance calibrations
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        ra = $urandom_range(0, 4095); rb = $urandom_range(0, 4095); rc = $urandom_range(0, 4095);
      end else begin
        ra = $urandom_range(1750, 2350); rb = $urandom_range(1750, 2350); rc = $urandom_range(1750, 2350);
      end
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, ra, rb, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
